// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states,
// RV32I load/store width codes, word-address type and the legality check.
package lsu_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef logic [29:0] word_addr_t;

    // A request is an error when misaligned for its width or when the width
    // code is not defined for its direction (stores only have B/H/W).
    function automatic logic req_is_err(input logic       we,
                                        input logic [2:0] funct3,
                                        input logic [1:0] byte_off);
        logic err;
        err = 1'b0;
        case (funct3)
            F3_B:    err = 1'b0;
            F3_BU:   err = we;
            F3_H:    err = byte_off[0];
            F3_HU:   err = we | byte_off[0];
            F3_W:    err = (byte_off != 2'b00);
            default: err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: store byte mask / replicated write data and
// load byte/half extraction with sign or zero extension.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_byte_off,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_mem_rd,
    output logic [3:0]  o_wmask,
    output logic [31:0] o_wd,
    output logic [31:0] o_rdata
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Store side: width is funct3[1:0] (0 byte, 1 half, 2 word).
    always_comb begin
        o_wmask = 4'b0000;
        o_wd    = i_wdata;
        case (i_funct3[1:0])
            2'd0: begin
                o_wmask = 4'b0001 << i_byte_off;
                o_wd    = {4{i_wdata[7:0]}};
            end
            2'd1: begin
                o_wmask = i_byte_off[1] ? 4'b1100 : 4'b0011;
                o_wd    = {2{i_wdata[15:0]}};
            end
            2'd2: begin
                o_wmask = 4'b1111;
                o_wd    = i_wdata;
            end
            default: begin
                o_wmask = 4'b0000;
                o_wd    = i_wdata;
            end
        endcase
    end

    // Load side: pick the addressed byte/half then extend per width code.
    always_comb begin
        w_byte = 8'h00;
        case (i_byte_off)
            2'd0:    w_byte = i_mem_rd[7:0];
            2'd1:    w_byte = i_mem_rd[15:8];
            2'd2:    w_byte = i_mem_rd[23:16];
            default: w_byte = i_mem_rd[31:24];
        endcase
        w_half  = i_byte_off[1] ? i_mem_rd[31:16] : i_mem_rd[15:0];
        o_rdata = 32'h0;
        case (i_funct3)
            F3_B:    o_rdata = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_rdata = {24'h0, w_byte};
            F3_H:    o_rdata = {{16{w_half[15]}}, w_half};
            F3_HU:   o_rdata = {16'h0, w_half};
            F3_W:    o_rdata = i_mem_rd;
            default: o_rdata = 32'h0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: IDLE -> ACCESS (MEM_LAT cycles) -> RESP handshake FSM
// in front of a single-port data memory with combinational read.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_we,
    output logic [3:0]  mem_wmask,
    output logic [29:0] mem_A,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

    lsu_state_t  r_state;
    lsu_state_t  w_state_next;
    logic [3:0]  r_cnt;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic [2:0]  r_funct3;
    logic        r_we;
    logic        r_err;

    logic        w_accept;
    logic        w_req_err;
    logic        w_last;
    logic [3:0]  w_wmask;
    logic [31:0] w_wd;
    logic [31:0] w_rdata;
    word_addr_t  w_word_addr;

    assign w_accept    = req_valid && req_ready;
    assign w_req_err   = req_is_err(req_we, req_funct3, req_addr[1:0]);
    assign w_last      = (r_cnt == 4'd0);
    assign w_word_addr = r_addr[31:2];

    lsu_lane_align u_align (
        .i_funct3   (r_funct3),
        .i_byte_off (r_addr[1:0]),
        .i_wdata    (r_wdata),
        .i_mem_rd   (mem_rd),
        .o_wmask    (w_wmask),
        .o_wd       (w_wd),
        .o_rdata    (w_rdata)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    // Next-state: errors skip memory entirely and respond next cycle.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_state_next = w_req_err ? S_RESP : S_ACCESS;
            S_ACCESS: if (w_last)   w_state_next = S_RESP;
            S_RESP:   if (resp_ready) w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // Access-cycle counter: loaded on a legal accept, counts down to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= 4'd0;
        end else if (r_state == S_IDLE && w_accept && !w_req_err) begin
            r_cnt <= LAT_M1;
        end else if (r_state == S_ACCESS && !w_last) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // Request capture; only legal requests update the memory-facing fields
    // so mem_A / mem_wd keep their last values across error requests.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr   <= 32'h0;
            r_wdata  <= 32'h0;
            r_funct3 <= 3'd0;
            r_we     <= 1'b0;
            r_err    <= 1'b0;
        end else if (w_accept) begin
            r_err <= w_req_err;
            if (!w_req_err) begin
                r_addr   <= req_addr;
                r_wdata  <= req_wdata;
                r_funct3 <= req_funct3;
                r_we     <= req_we;
            end
        end
    end

    // Response data: load result sampled on the edge leaving ACCESS.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= 32'h0;
        end else if (w_accept && w_req_err) begin
            r_rdata <= 32'h0;
        end else if (r_state == S_ACCESS && w_last) begin
            r_rdata <= r_we ? 32'h0 : w_rdata;
        end
    end

    assign req_ready  = (r_state == S_IDLE) && !rst;
    assign resp_valid = (r_state == S_RESP);
    assign resp_err   = resp_valid && r_err;
    assign resp_rdata = resp_valid ? r_rdata : 32'h0;
    assign mem_we     = (r_state == S_ACCESS) && r_we && w_last;
    assign mem_wmask  = (r_state == S_ACCESS) ? w_wmask : 4'b0000;
    assign mem_A      = w_word_addr;
    assign mem_wd     = w_wd;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit (MEM_LAT=3) with a byte-masked
// word memory model attached to the memory port.
module tb_load_store_unit;

    localparam int LAT = 3;

    typedef struct packed {
        logic [31:0] rd;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_we;
    logic [3:0]  mem_wmask;
    logic [29:0] mem_A;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    logic [31:0] mem [0:255];
    int          we_count = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    exp_t        exp_q[$];

    logic [29:0] cap_a;
    logic [3:0]  cap_mask;
    logic [31:0] cap_wd;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_LAT(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_we     (mem_we),
        .mem_wmask  (mem_wmask),
        .mem_A      (mem_A),
        .mem_wd     (mem_wd),
        .mem_rd     (mem_rd)
    );

    // Memory model: combinational read, byte-masked synchronous write.
    assign mem_rd = mem[mem_A[7:0]];
    always @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++)
                if (mem_wmask[b]) mem[mem_A[7:0]][b*8 +: 8] <= mem_wd[b*8 +: 8];
            we_count++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every handshaken response is compared with the queue head.
    always @(negedge clk) begin
        if (!rst && resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL resp_unexpected: got rdata 0x%08h err %0b, want no response",
                         resp_rdata, resp_err);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("resp_rdata", resp_rdata, e.rd);
                chk("resp_err", {31'h0, resp_err}, {31'h0, e.err});
                $display("[TB] resp rdata=0x%08h err=%0b", resp_rdata, resp_err);
            end
        end
    end

    // Issue one request with resp_ready high; checks latency and write pulses.
    task automatic issue(input string name, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rd, input logic exp_err,
                         input int exp_pulses);
        int k;
        int pulses0;
        bit got;
        exp_t e;
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = we; req_funct3 = f3;
        req_addr = addr; req_wdata = wdata;
        @(negedge clk);
        chk({name, "_ready"}, {31'h0, req_ready}, 32'h1);
        e.rd = exp_rd; e.err = exp_err;
        exp_q.push_back(e);
        pulses0 = we_count;
        @(posedge clk); #1;
        req_valid = 1'b0;
        k = 0; got = 1'b0;
        while (!got && k < 40) begin
            @(negedge clk);
            k++;
            if (mem_we) begin
                cap_a = mem_A; cap_mask = mem_wmask; cap_wd = mem_wd;
            end
            if (resp_valid) got = 1'b1;
        end
        chk({name, "_lat"}, k, exp_err ? 32'd1 : 32'(LAT + 1));
        @(posedge clk); #1;
        chk({name, "_wepulses"}, we_count - pulses0, exp_pulses);
        $display("[TB] %s we=%0b f3=%0d addr=0x%08h wdata=0x%08h", name, we, f3, addr, wdata);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #12;
        chk("rst_req_ready", {31'h0, req_ready}, 32'h0);
        chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
        chk("rst_mem_wmask", {28'h0, mem_wmask}, 32'h0);
        chk("rst_mem_A", {2'b0, mem_A}, 32'h0);
        chk("rst_mem_wd", mem_wd, 32'h0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", {31'h0, req_ready}, 32'h1);

        // Stores and loads with sign/zero extension
        issue("SW_100", 1, 3'd2, 32'h100, 32'h0080FF00, 32'h0, 0, 1);
        issue("LB_102", 0, 3'd0, 32'h102, 32'h0, 32'hFFFFFF80, 0, 0);
        issue("LBU_102", 0, 3'd4, 32'h102, 32'h0, 32'h00000080, 0, 0);
        issue("LH_102", 0, 3'd1, 32'h102, 32'h0, 32'h00000080, 0, 0);
        issue("LHU_100", 0, 3'd5, 32'h100, 32'h0, 32'h0000FF00, 0, 0);
        issue("LH_100", 0, 3'd1, 32'h100, 32'h0, 32'hFFFFFF00, 0, 0);
        issue("LW_100", 0, 3'd2, 32'h100, 32'h0, 32'h0080FF00, 0, 0);
        issue("SB_103", 1, 3'd0, 32'h103, 32'h000000AB, 32'h0, 0, 1);
        chk("SB_103_memA", {2'b0, cap_a}, 32'h40);
        chk("SB_103_mask", {28'h0, cap_mask}, 32'h8);
        chk("SB_103_wd", cap_wd, 32'hABABABAB);
        issue("LW_100b", 0, 3'd2, 32'h100, 32'h0, 32'hAB80FF00, 0, 0);
        issue("SW_20", 1, 3'd2, 32'h20, 32'h0, 32'h0, 0, 1);
        issue("SH_22", 1, 3'd1, 32'h22, 32'h12345678, 32'h0, 0, 1);
        chk("SH_22_mask", {28'h0, cap_mask}, 32'hC);
        chk("SH_22_wd", cap_wd, 32'h56785678);
        issue("LW_20", 0, 3'd2, 32'h20, 32'h0, 32'h56780000, 0, 0);

        // Error requests: one-cycle response, no memory write
        issue("LW_106_err", 0, 3'd2, 32'h106, 32'h0, 32'h0, 1, 0);
        issue("LD3_err", 0, 3'd3, 32'h100, 32'h0, 32'h0, 1, 0);
        issue("ST4_err", 1, 3'd4, 32'h100, 32'h55, 32'h0, 1, 0);
        issue("SH_101_err", 1, 3'd1, 32'h101, 32'h55, 32'h0, 1, 0);
        issue("LHU_103_err", 0, 3'd5, 32'h103, 32'h0, 32'h0, 1, 0);
        issue("SW_102_err", 1, 3'd2, 32'h102, 32'h55, 32'h0, 1, 0);
        issue("LW_100c", 0, 3'd2, 32'h100, 32'h0, 32'hAB80FF00, 0, 0);

        // SW with response back-pressure for two cycles
        begin
            exp_t e;
            @(posedge clk); #1;
            resp_ready = 1'b0;
            req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2;
            req_addr = 32'h20; req_wdata = 32'hCAFEF00D;
            @(negedge clk);
            chk("bp_accept_ready", {31'h0, req_ready}, 32'h1);
            e.rd = 32'h0; e.err = 1'b0;
            exp_q.push_back(e);
            @(posedge clk); #1 req_valid = 1'b0;
            for (int c = 1; c <= 3; c++) begin
                @(negedge clk);
                chk("bp_access_we", {31'h0, mem_we}, (c == 3) ? 32'h1 : 32'h0);
                chk("bp_access_ready", {31'h0, req_ready}, 32'h0);
                chk("bp_access_mask", {28'h0, mem_wmask}, 32'hF);
            end
            for (int c = 1; c <= 3; c++) begin
                @(posedge clk); #1;
                if (c == 3) resp_ready = 1'b1;
                @(negedge clk);
                chk("bp_resp_valid", {31'h0, resp_valid}, 32'h1);
                chk("bp_resp_ready_out", {31'h0, req_ready}, 32'h0);
                chk("bp_resp_we", {31'h0, mem_we}, 32'h0);
            end
            @(posedge clk); #1;
            @(negedge clk);
            chk("bp_done_valid", {31'h0, resp_valid}, 32'h0);
            chk("bp_done_ready", {31'h0, req_ready}, 32'h1);
            $display("[TB] SW_20 back-pressure 0x%08h", 32'hCAFEF00D);
        end
        issue("LW_20b", 0, 3'd2, 32'h20, 32'h0, 32'hCAFEF00D, 0, 0);

        // Reset in the final ACCESS cycle of a store
        issue("SW_24", 1, 3'd2, 32'h24, 32'h11223344, 32'h0, 0, 1);
        begin
            int pulses0;
            pulses0 = we_count;
            @(posedge clk); #1;
            req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2;
            req_addr = 32'h24; req_wdata = 32'hDEADBEEF;
            @(negedge clk);
            chk("rstmid_ready", {31'h0, req_ready}, 32'h1);
            @(posedge clk); #1 req_valid = 1'b0;
            @(posedge clk);
            @(posedge clk); #1;
            chk("rstmid_we_before", {31'h0, mem_we}, 32'h1);
            #1 rst = 1'b1;
            #1;
            chk("rstmid_we_drop", {31'h0, mem_we}, 32'h0);
            chk("rstmid_mask", {28'h0, mem_wmask}, 32'h0);
            chk("rstmid_ready_low", {31'h0, req_ready}, 32'h0);
            chk("rstmid_valid", {31'h0, resp_valid}, 32'h0);
            @(posedge clk); #1 rst = 1'b0;
            @(negedge clk);
            chk("rstmid_ready_after", {31'h0, req_ready}, 32'h1);
            chk("rstmid_mem", mem[9], 32'h11223344);
            chk("rstmid_pulses", we_count - pulses0, 32'h0);
            $display("[TB] SW_24 aborted by reset");
        end
        issue("LW_24", 0, 3'd2, 32'h24, 32'h0, 32'h11223344, 0, 0);

        @(negedge clk);
        chk("queue_empty", exp_q.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
